// File: rtl/sopc_bus_ctrl.sv
// CPU-to-slave bus controller: decodes m_addr[31:28] into a one-hot slave request and
// stalls the CPU until ack. Optional REQ timeout when SOPC_BUS_TIMEOUT_EN is defined.
module sopc_bus_ctrl #(
   parameter int NUM_SLV     = 4,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   m_ce,
   input  logic                   m_we,
   input  logic [31:0]            m_addr,
   input  logic [3:0]             m_sel,
   input  logic [31:0]            m_wdata,
   output logic [31:0]            m_rdata,
   output logic                   m_stall,
   output logic                   m_err,
   output logic [31:0]            err_addr,
   output logic [NUM_SLV-1:0]     s_req,
   output logic                   s_we,
   output logic [31:0]            s_addr,
   output logic [3:0]             s_sel,
   output logic [31:0]            s_wdata,
   input  logic [32*NUM_SLV-1:0]  s_rdata,
   input  logic [NUM_SLV-1:0]     s_ack
);

   typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
   state_t state;

   logic               legal;
   logic [NUM_SLV-1:0] dec;
   logic               ack_hit;
   logic [31:0]        sel_rdata;

   assign legal   = ({28'd0, m_addr[31:28]} < 32'(NUM_SLV));
   // Masking with the registered one-hot s_req drops acks from unselected slaves.
   assign ack_hit = |(s_ack & s_req);
   assign m_stall = ((state == IDLE) && m_ce) || (state == REQ);

   always_comb begin
      dec       = '0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         dec[i] = (m_addr[31:28] == 4'(i));
         if (s_req[i]) sel_rdata = sel_rdata | s_rdata[32*i +: 32];
      end
   end

`ifdef SOPC_BUS_TIMEOUT_EN
   logic [7:0] cnt;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         s_req    <= '0;
         s_we     <= 1'b0;
         s_addr   <= '0;
         s_sel    <= '0;
         s_wdata  <= '0;
         m_rdata  <= '0;
         m_err    <= 1'b0;
         err_addr <= '0;
`ifdef SOPC_BUS_TIMEOUT_EN
         cnt      <= '0;
`endif
      end else begin
         m_err <= 1'b0;
         case (state)
            IDLE: begin
               if (m_ce) begin
                  if (legal) begin
                     s_we    <= m_we;
                     s_addr  <= m_addr;
                     s_sel   <= m_sel;
                     s_wdata <= m_wdata;
                     s_req   <= dec;
`ifdef SOPC_BUS_TIMEOUT_EN
                     cnt     <= '0;
`endif
                     state   <= REQ;
                  end else begin
                     err_addr <= m_addr;
                     m_rdata  <= '0;
                     m_err    <= 1'b1;
                     state    <= ERR;
                  end
               end
            end
            REQ: begin
               // Ack is checked first so an ack in the last permitted cycle beats the timeout.
               if (ack_hit) begin
                  m_rdata <= s_we ? 32'd0 : sel_rdata;
                  s_req   <= '0;
                  state   <= DONE;
               end
`ifdef SOPC_BUS_TIMEOUT_EN
               else if (cnt == 8'(TIMEOUT_CYC - 1)) begin
                  err_addr <= s_addr;
                  m_rdata  <= '0;
                  m_err    <= 1'b1;
                  s_req    <= '0;
                  state    <= ERR;
               end else begin
                  cnt <= cnt + 8'd1;
               end
`endif
            end
            DONE:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sopc_bus_ctrl.sv
// Scoreboard bench for sopc_bus_ctrl: driver pushes expected completions, a negedge
// monitor pops them when the stall ends. Timeout cases apply when SOPC_BUS_TIMEOUT_EN is set.
module tb_sopc_bus_ctrl;
   localparam int N  = 4;
   localparam int TO = 16;
`ifdef SOPC_BUS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            m_ce, m_we;
   logic [31:0]     m_addr, m_wdata;
   logic [3:0]      m_sel;
   logic [31:0]     m_rdata, err_addr;
   logic            m_stall, m_err;
   logic [N-1:0]    s_req;
   logic            s_we;
   logic [31:0]     s_addr, s_wdata;
   logic [3:0]      s_sel;
   logic [32*N-1:0] s_rdata;
   logic [N-1:0]    s_ack;

   sopc_bus_ctrl #(.NUM_SLV(N), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_sel(m_sel),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .m_stall(m_stall), .m_err(m_err),
      .err_addr(err_addr), .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_sel(s_sel),
      .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      logic [31:0] eaddr;
      int          stalls;
   } exp_t;

   typedef struct {
      logic [N-1:0] req;
      logic         we;
      logic [31:0]  addr;
      logic [3:0]   sel;
      logic [31:0]  wdata;
   } cmd_t;

   exp_t q[$];
   cmd_t exp_cmd;
   int   checks = 0;
   int   failures = 0;

   // Monitor: checks the shared command while a request is out, pops on each completion.
   int          stall_cnt = 0;
   bit          prev_stall = 0;
   logic [31:0] last_rdata = 0;
   logic [31:0] last_eaddr = 0;

   always @(negedge clk) begin
      if (!rst) begin
         stall_cnt  = 0;
         prev_stall = 0;
         last_rdata = 0;
         last_eaddr = 0;
      end else begin
         if (m_stall) stall_cnt++;
         if (s_req != '0) begin
            checks++;
            if (s_req !== exp_cmd.req || s_we !== exp_cmd.we || s_addr !== exp_cmd.addr ||
                s_sel !== exp_cmd.sel || s_wdata !== exp_cmd.wdata) begin
               failures++;
               $display("FAIL s_cmd: got req=%b we=%b addr=%h sel=%h wdata=%h, need req=%b we=%b addr=%h sel=%h wdata=%h",
                        s_req, s_we, s_addr, s_sel, s_wdata, exp_cmd.req, exp_cmd.we,
                        exp_cmd.addr, exp_cmd.sel, exp_cmd.wdata);
            end
         end
         if (prev_stall && !m_stall) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL completion: unexpected completion, err=%b rdata=%h", m_err, m_rdata);
            end else begin
               exp_t e;
               logic [31:0] ea;
               e  = q.pop_front();
               ea = e.err ? e.eaddr : last_eaddr;
               if (m_err !== e.err || m_rdata !== e.rdata || err_addr !== ea ||
                   s_req !== '0 || stall_cnt != e.stalls) begin
                  failures++;
                  $display("FAIL completion: got err=%b rdata=%h eaddr=%h s_req=%b stalls=%0d, need err=%b rdata=%h eaddr=%h s_req=0 stalls=%0d",
                           m_err, m_rdata, err_addr, s_req, stall_cnt, e.err, e.rdata, ea, e.stalls);
               end
               last_rdata = e.rdata;
               last_eaddr = ea;
            end
            stall_cnt = 0;
         end else if (!m_stall) begin
            checks++;
            if (m_err !== 1'b0 || m_rdata !== last_rdata || err_addr !== last_eaddr) begin
               failures++;
               $display("FAIL idle_hold: got err=%b rdata=%h eaddr=%h, need err=0 rdata=%h eaddr=%h",
                        m_err, m_rdata, err_addr, last_rdata, last_eaddr);
            end
         end
         prev_stall = m_stall;
      end
   end

   task automatic set_slaves(input int idx, input logic [31:0] rd);
      for (int i = 0; i < N; i++) s_rdata[32*i +: 32] = (i == idx) ? rd : $urandom;
   endtask

   // d = REQ cycle on which the selected slave acks (1 = first); d = 0 never acks.
   task automatic access(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wdata, input logic [31:0] rd, input int d);
      exp_t        e;
      int          idx, nreq;
      bit          hold;
      logic [31:0] tmp;
      logic [N-1:0] onehot, noise;
      idx    = {28'd0, addr[31:28]};
      onehot = '0;
      for (int i = 0; i < N; i++) if (i == idx) onehot[i] = 1'b1;
      if (idx >= N) begin
         e.err = 1'b1; e.rdata = 0; e.eaddr = addr; nreq = 0;
      end else if (TO_EN && (d == 0 || d > TO)) begin
         e.err = 1'b1; e.rdata = 0; e.eaddr = addr; nreq = TO;
      end else begin
         e.err = 1'b0; e.rdata = we ? 32'd0 : rd; e.eaddr = 0; nreq = d;
      end
      e.stalls = 1 + nreq;
      q.push_back(e);
      exp_cmd.req = onehot; exp_cmd.we = we; exp_cmd.addr = addr;
      exp_cmd.sel = sel; exp_cmd.wdata = wdata;
      m_ce = 1'b1; m_we = we; m_addr = addr; m_sel = sel; m_wdata = wdata;
      set_slaves(idx, rd);
      @(posedge clk); #1;
      hold = ($urandom % 2) == 1;
      if (!hold) m_ce = 1'b0;
      for (int k = 1; k <= nreq; k++) begin
         tmp   = $urandom;
         noise = tmp[N-1:0] & ~onehot;
         s_ack = (k == d) ? (noise | onehot) : noise;
         set_slaves(idx, rd);
         @(posedge clk); #1;
      end
      s_ack = '0;
      @(posedge clk); #1;
      m_ce = 1'b0;
      repeat ($urandom % 3) begin @(posedge clk); #1; end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish within time bound");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, t;
      int          idx, d;
      rst = 1'b0; m_ce = 0; m_we = 0; m_addr = 0; m_sel = 0; m_wdata = 0;
      s_rdata = '0; s_ack = '0;
      exp_cmd = '{req: '0, we: 1'b0, addr: 0, sel: 0, wdata: 0};
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (m_rdata !== 0 || m_err !== 0 || err_addr !== 0 || s_req !== 0 || s_we !== 0 ||
          s_addr !== 0 || s_sel !== 0 || s_wdata !== 0 || m_stall !== 0) begin
         failures++;
         $display("FAIL reset: got rdata=%h err=%b eaddr=%h req=%b we=%b addr=%h sel=%h wdata=%h stall=%b, need all 0",
                  m_rdata, m_err, err_addr, s_req, s_we, s_addr, s_sel, s_wdata, m_stall);
      end
      rst = 1'b1;
      @(posedge clk); #1;

      access(32'h2000_0010, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1);
      access(32'h1000_0004, 1'b1, 4'b0011, 32'h1234_5678, 32'hAAAA_5555, 5);
      access(32'h7000_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1);
      access(32'h3000_0008, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D, 3);
      if (TO_EN) begin
         access(32'h0000_0000, 1'b0, 4'hF, 32'h0, 32'hCAFE_0000, 0);
         access(32'h0000_0000, 1'b0, 4'hF, 32'h0, 32'hCAFE_0016, TO);
      end

      // Bogus ack from slave 3 while slave 1 is selected, then reset mid-REQ.
      exp_cmd = '{req: 4'b0010, we: 1'b0, addr: 32'h1000_0020, sel: 4'hF, wdata: 0};
      m_ce = 1'b1; m_we = 1'b0; m_addr = 32'h1000_0020; m_sel = 4'hF; m_wdata = 0;
      @(posedge clk); #1;
      m_ce = 1'b0;
      s_ack = 4'b1000;
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if (m_stall !== 1'b1 || s_req !== 4'b0010) begin
         failures++;
         $display("FAIL ignore_ack: got stall=%b s_req=%b, need stall=1 s_req=0010", m_stall, s_req);
      end
      s_ack = '0;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (s_req !== 0 || m_err !== 0 || m_stall !== 0) begin
         failures++;
         $display("FAIL reset_abort: got s_req=%b err=%b stall=%b, need 0 0 0", s_req, m_err, m_stall);
      end
      rst = 1'b1;
      @(posedge clk); #1;

      for (int n = 0; n < 60; n++) begin
         idx = ($urandom % 4 == 0) ? $urandom_range(N, 15) : $urandom_range(0, N - 1);
         t   = $urandom;
         a   = {idx[3:0], t[27:0]};
         if (TO_EN) d = ($urandom % 6 == 0) ? 0 : $urandom_range(1, TO + 2);
         else       d = $urandom_range(1, 8);
         access(a, ($urandom % 2) == 1, 4'($urandom), $urandom, $urandom, d);
      end

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending completions, need 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
